imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
Shares one single-ported RAM between the core's instruction-fetch port and data port, both using the req/gnt/rvalid protocol. Arbitrates requests, holds the winning selection stable until the RAM grants, and tracks the source of each in-flight access in an in-order ID FIFO. Each rvalid is routed back to the requester that issued it. Sits between the core-side memory interfaces and the RAM model in the compliance harness.

Parameters:
MaxOutstanding, 2, max granted-but-unanswered RAM transactions (1..4)
ArbMode, 0, 0 = fixed priority (data wins), 1 = round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_addr_i  in  32  fetch address
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch error
data_req_i  in  1  data request
data_gnt_o  out  1  data request accepted
data_rvalid_o  out  1  data response valid
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  write data
data_rdata_o  out  32  data read data
data_err_o  out  1  data error
mem_req_o  out  1  RAM request
mem_gnt_i  in  1  RAM grant
mem_rvalid_i  in  1  RAM response valid
mem_addr_o  out  32  RAM address
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data
mem_err_i  in  1  RAM error
unexp_rvalid_o  out  1  sticky flag: rvalid received with no transaction outstanding

Behaviour:
- Reset values: all *_gnt_o, *_rvalid_o, mem_req_o, unexp_rvalid_o = 0. FIFO empty. FSM = IDLE. Round-robin last-winner = INSTR, so data wins the first tie.
- Clock and reset: single clock clk_i; rst_i is asynchronous and active-high.
- FSM IDLE:
  - If the FIFO is not full and any request is present, select a winner. ArbMode 0: data beats instr. ArbMode 1: on a tie, the source opposite to the last winner; otherwise the sole requester.
  - Drive mem_req_o = 1 and mux the winner's addr/we/be/wdata onto the mem_* outputs. Instr side forces we = 0, be = 4'hF, wdata = 0.
  - If mem_gnt_i = 1 in the same cycle: assert the winner's *_gnt_o, push the winner ID, update the last winner, stay in IDLE.
  - If mem_gnt_i = 0: go to PENDING and latch the winner.
- FSM PENDING:
  - Keep the latched selection regardless of the other requester; mem_* fields follow the latched requester's inputs (that requester must hold them per protocol).
  - On mem_gnt_i: assert its gnt, push its ID, return to IDLE.
  - If the latched requester drops req (protocol violation): deassert mem_req_o and return to IDLE. No push.
- Grant path is combinational; the arbiter adds zero cycles of latency.
- FIFO full: mem_req_o = 0 and no requester is granted, even if a pop occurs in the same cycle. A new grant is possible from the next cycle.
- Response routing:
  - On mem_rvalid_i with the FIFO non-empty: pop; assert the head ID's rvalid in the same cycle; copy mem_err_i to that side's err.
  - Both *_rdata_o are continuously driven with mem_rdata_i (never X). rvalid/err are asserted only on the owning side.
- Simultaneous push and pop with the FIFO not full: both take effect; the occupancy count is unchanged.
- mem_rvalid_i with the FIFO empty: response dropped; unexp_rvalid_o set to 1 and held until reset.
- Reset mid-operation: FIFO and FSM cleared immediately. Responses still in flight afterwards hit the empty-FIFO rule and are flagged.
- Occupancy counter width: $clog2(MaxOutstanding+1). The FIFO pointers wrap modulo MaxOutstanding.

Decomposition:
- Package mem_arb_pkg: enum src_e {SRC_INSTR, SRC_DATA}; enum arb_state_e {IDLE, PENDING}; constant ARB_FIXED = 0, ARB_RR = 1.
- Sub-module mem_arb_id_fifo: src_e-wide, depth MaxOutstanding, with push/pop/full/empty/head outputs.

Test Plan:
1. Instr read only, mem_gnt_i in the request cycle, rvalid 2 cycles later with rdata = 32'h0000_0013 -> instr_gnt_o in the same cycle; instr_rvalid_o = 1 and instr_rdata_o = 32'h13 two cycles later; data_rvalid_o stays 0.
2. Both request in the same cycle, ArbMode 0, addr 0x100 and 0x2000 -> data granted first, mem_addr_o = 0x2000; instr granted next cycle with 0x100; responses are routed data then instr.
3. ArbMode 1, both requesting continuously for 6 grants -> grant sequence D, I, D, I, D, I.
4. mem_gnt_i held low 3 cycles while instr is PENDING and data asserts req -> mem_addr_o stays at the instr address throughout; instr is granted on cycle 4; data is granted afterwards.
5. MaxOutstanding = 2, two grants with no rvalid -> mem_req_o = 0 with req pending. One rvalid -> next cycle mem_req_o = 1 and a grant is possible. mem_err_i = 1 on a data response -> data_err_o = 1 only.
6. rvalid with the FIFO empty -> unexp_rvalid_o = 1 and held. Assert rst_i mid-transaction -> FIFO cleared, outputs return to reset values, and the late rvalid is flagged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the imem/dmem port arbiter
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Round-robin tie break: the side that did not win last time
    function automatic src_e opposite_src(input src_e s);
        return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - in-order FIFO of requester IDs for in-flight RAM accesses
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  src_e push_id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output src_e head_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    src_e            entries [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at Depth, which need not be a power of two
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags and head entry
    always_comb begin
        full_o  = (count == CntW'(Depth));
        empty_o = (count == '0);
        head_o  = entries[rd_ptr];
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
    end

    // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= SRC_INSTR;
            end
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_id_i;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - shares one RAM port between instruction fetch and data access
module imem_dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int ArbMode        = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        unexp_rvalid_o
);

    arb_state_e state_q;
    src_e       latched_q;
    src_e       last_q;
    logic       unexp_q;

    src_e       winner;
    src_e       sel_src;
    logic       sel_req;
    logic       grant;
    logic       fifo_full;
    logic       fifo_empty;
    src_e       fifo_head;
    logic       pop;

    // Pick a winner among fresh requests, or keep the latched one while waiting for the RAM
    always_comb begin
        if (instr_req_i && data_req_i) begin
            winner = (ArbMode == ARB_RR) ? opposite_src(last_q) : SRC_DATA;
        end else if (data_req_i) begin
            winner = SRC_DATA;
        end else begin
            winner = SRC_INSTR;
        end
        sel_src   = (state_q == PENDING) ? latched_q : winner;
        sel_req   = (sel_src == SRC_DATA) ? data_req_i : instr_req_i;
        // A full FIFO blocks the request even if a pop frees a slot this cycle
        mem_req_o = sel_req && !fifo_full;
        grant     = mem_req_o && mem_gnt_i;
        instr_gnt_o = grant && (sel_src == SRC_INSTR);
        data_gnt_o  = grant && (sel_src == SRC_DATA);
    end

    // RAM request fields follow the selected requester; fetches are always full-word reads
    always_comb begin
        if (sel_src == SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_wdata_o = 32'h0;
        end
    end

    // Route each response to the side at the head of the ID FIFO
    always_comb begin
        pop            = mem_rvalid_i && !fifo_empty;
        instr_rvalid_o = pop && (fifo_head == SRC_INSTR);
        data_rvalid_o  = pop && (fifo_head == SRC_DATA);
        instr_err_o    = instr_rvalid_o && mem_err_i;
        data_err_o     = data_rvalid_o && mem_err_i;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        unexp_rvalid_o = unexp_q;
    end

    // Arbiter FSM, latched selection and round-robin history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            latched_q <= SRC_INSTR;
            last_q    <= SRC_INSTR;
        end else begin
            if (grant) begin
                last_q <= sel_src;
            end
            case (state_q)
                IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q   <= PENDING;
                        latched_q <= sel_src;
                    end
                end
                PENDING: begin
                    // Either granted, or the requester withdrew against protocol
                    if (grant || !sel_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky flag for a response that has no matching outstanding access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            unexp_q <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            unexp_q <= 1'b1;
        end
    end

    mem_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (grant),
        .push_id_i (sel_src),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - self-checking bench for the imem/dmem port arbiter
module tb_imem_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: fixed priority instance, index 1: round-robin instance
    logic        ireq [2];
    logic [31:0] iaddr [2];
    logic        dreq [2];
    logic        dwe [2];
    logic [3:0]  dbe [2];
    logic [31:0] daddr [2];
    logic [31:0] dwdata [2];
    logic        mgnt [2];
    logic        mrv [2];
    logic        merr [2];
    logic [31:0] mrdata [2];

    logic        igrant [2];
    logic        irv [2];
    logic        ierr [2];
    logic [31:0] irdata [2];
    logic        dgnt [2];
    logic        drv [2];
    logic        derr [2];
    logic [31:0] drdata [2];
    logic        mreq [2];
    logic [31:0] maddr [2];
    logic        mwe [2];
    logic [3:0]  mbe [2];
    logic [31:0] mwdata [2];
    logic        unexp [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        imem_dmem_port_arbiter #(
            .MaxOutstanding (2),
            .ArbMode        (g)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .instr_req_i    (ireq[g]),
            .instr_gnt_o    (igrant[g]),
            .instr_rvalid_o (irv[g]),
            .instr_addr_i   (iaddr[g]),
            .instr_rdata_o  (irdata[g]),
            .instr_err_o    (ierr[g]),
            .data_req_i     (dreq[g]),
            .data_gnt_o     (dgnt[g]),
            .data_rvalid_o  (drv[g]),
            .data_we_i      (dwe[g]),
            .data_be_i      (dbe[g]),
            .data_addr_i    (daddr[g]),
            .data_wdata_i   (dwdata[g]),
            .data_rdata_o   (drdata[g]),
            .data_err_o     (derr[g]),
            .mem_req_o      (mreq[g]),
            .mem_gnt_i      (mgnt[g]),
            .mem_rvalid_i   (mrv[g]),
            .mem_addr_o     (maddr[g]),
            .mem_we_o       (mwe[g]),
            .mem_be_o       (mbe[g]),
            .mem_wdata_o    (mwdata[g]),
            .mem_rdata_i    (mrdata[g]),
            .mem_err_i      (merr[g]),
            .unexp_rvalid_o (unexp[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", name, m, $time, act, exp);
        end
    endtask

    // Behavioural model: list of in-flight IDs (0 = instr, 1 = data), head at index 0
    int fifo_m [2][4];
    int cnt_m [2];
    bit pend_m [2];
    int psrc_m [2];
    int last_m [2];
    bit unexp_m [2];
    bit seen_ig [2];
    bit seen_dg [2];

    // Per-cycle compare of both instances against the model, then advance the model
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int src;
            bit sreq, full, e_req, e_g, pop;
            int head;
            if (rst) begin
                cnt_m[m] = 0; pend_m[m] = 0; last_m[m] = 0; unexp_m[m] = 0;
            end
            if (pend_m[m]) src = psrc_m[m];
            else if (ireq[m] && dreq[m]) src = (m == 1) ? ((last_m[m] == 0) ? 1 : 0) : 1;
            else src = dreq[m] ? 1 : 0;
            sreq  = (src == 1) ? dreq[m] : ireq[m];
            full  = (cnt_m[m] == 2);
            e_req = sreq && !full;
            e_g   = e_req && mgnt[m];
            pop   = mrv[m] && (cnt_m[m] > 0);
            head  = fifo_m[m][0];

            chk("mem_req", m, 32'(mreq[m]), 32'(e_req));
            chk("instr_gnt", m, 32'(igrant[m]), 32'(e_g && src == 0));
            chk("data_gnt", m, 32'(dgnt[m]), 32'(e_g && src == 1));
            if (e_req) begin
                chk("mem_addr", m, maddr[m], (src == 1) ? daddr[m] : iaddr[m]);
                chk("mem_we", m, 32'(mwe[m]), (src == 1) ? 32'(dwe[m]) : 32'd0);
                chk("mem_be", m, 32'(mbe[m]), (src == 1) ? 32'(dbe[m]) : 32'hF);
                chk("mem_wdata", m, mwdata[m], (src == 1) ? dwdata[m] : 32'd0);
            end
            chk("instr_rvalid", m, 32'(irv[m]), 32'(pop && head == 0));
            chk("data_rvalid", m, 32'(drv[m]), 32'(pop && head == 1));
            chk("instr_err", m, 32'(ierr[m]), 32'(pop && head == 0 && merr[m]));
            chk("data_err", m, 32'(derr[m]), 32'(pop && head == 1 && merr[m]));
            chk("instr_rdata", m, irdata[m], mrdata[m]);
            chk("data_rdata", m, drdata[m], mrdata[m]);
            chk("unexp", m, 32'(unexp[m]), 32'(unexp_m[m]));

            if (!rst) begin
                if (mrv[m] && cnt_m[m] == 0) unexp_m[m] = 1;
                if (pop) begin
                    for (int k = 0; k < 3; k++) fifo_m[m][k] = fifo_m[m][k+1];
                    cnt_m[m]--;
                end
                if (e_g) begin
                    fifo_m[m][cnt_m[m]] = src;
                    cnt_m[m]++;
                    last_m[m] = src;
                    pend_m[m] = 0;
                end else if (pend_m[m] && !sreq) begin
                    pend_m[m] = 0;
                end else if (!pend_m[m] && e_req) begin
                    pend_m[m] = 1;
                    psrc_m[m] = src;
                end
            end
            seen_ig[m] = igrant[m];
            seen_dg[m] = dgnt[m];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            ireq[m] = 0; iaddr[m] = 0; dreq[m] = 0; dwe[m] = 0; dbe[m] = 0;
            daddr[m] = 0; dwdata[m] = 0; mgnt[m] = 0; mrv[m] = 0; merr[m] = 0; mrdata[m] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        look();
        chk("reset_mem_req", 0, 32'(mreq[0]), 0);
        chk("reset_unexp", 1, 32'(unexp[1]), 0);

        // Fetch only, granted immediately, response two cycles later
        cyc(); ireq[0] = 1; iaddr[0] = 32'h80; mgnt[0] = 1;
        look(); chk("t1_igrant", 0, 32'(igrant[0]), 1); chk("t1_addr", 0, maddr[0], 32'h80);
        cyc(); ireq[0] = 0; mgnt[0] = 0;
        look(); chk("t1_no_rvalid_early", 0, 32'(irv[0]), 0);
        cyc(); mrv[0] = 1; mrdata[0] = 32'h0000_0013;
        look(); chk("t1_irv", 0, 32'(irv[0]), 1); chk("t1_rdata", 0, irdata[0], 32'h13);
        chk("t1_drv", 0, 32'(drv[0]), 0);
        cyc(); mrv[0] = 0;

        // Fixed priority tie: data first, then fetch; responses in grant order
        ireq[0] = 1; iaddr[0] = 32'h100; dreq[0] = 1; daddr[0] = 32'h2000;
        dwe[0] = 1; dbe[0] = 4'h3; dwdata[0] = 32'hDEAD_BEEF; mgnt[0] = 1;
        look(); chk("t2_dgnt", 0, 32'(dgnt[0]), 1); chk("t2_igrant0", 0, 32'(igrant[0]), 0);
        chk("t2_addr_d", 0, maddr[0], 32'h2000); chk("t2_we", 0, 32'(mwe[0]), 1);
        cyc(); dreq[0] = 0;
        look(); chk("t2_igrant", 0, 32'(igrant[0]), 1); chk("t2_addr_i", 0, maddr[0], 32'h100);
        chk("t2_be_i", 0, 32'(mbe[0]), 32'hF);
        cyc(); ireq[0] = 0; mgnt[0] = 0; mrv[0] = 1; mrdata[0] = 32'h2222_0000;
        look(); chk("t2_resp1_d", 0, 32'(drv[0]), 1); chk("t2_resp1_i", 0, 32'(irv[0]), 0);
        cyc(); mrdata[0] = 32'h1111_0000;
        look(); chk("t2_resp2_i", 0, 32'(irv[0]), 1); chk("t2_resp2_d", 0, 32'(drv[0]), 0);
        cyc(); mrv[0] = 0;

        // Round-robin with both sides requesting continuously
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            ireq[1] = 1; dreq[1] = 1; iaddr[1] = 32'h1000 + 32'(4 * k);
            daddr[1] = 32'h8000 + 32'(4 * k); mgnt[1] = 1; mrv[1] = (k > 0);
            look();
            chk("t3_dgnt", k, 32'(dgnt[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_igrant", k, 32'(igrant[1]), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        cyc(); ireq[1] = 0; dreq[1] = 0; mgnt[1] = 0; mrv[1] = 1;
        cyc(); mrv[1] = 0;

        // Fetch waits three cycles for the RAM while data also requests
        ireq[0] = 1; iaddr[0] = 32'h300; dwe[0] = 0; dbe[0] = 4'hF;
        look(); chk("t4_addr_c1", 0, maddr[0], 32'h300); chk("t4_req_c1", 0, 32'(mreq[0]), 1);
        for (int k = 0; k < 2; k++) begin
            cyc(); dreq[0] = 1; daddr[0] = 32'h400;
            look(); chk("t4_addr_hold", k, maddr[0], 32'h300); chk("t4_dgnt_hold", k, 32'(dgnt[0]), 0);
        end
        cyc(); mgnt[0] = 1;
        look(); chk("t4_igrant", 0, 32'(igrant[0]), 1); chk("t4_addr_c4", 0, maddr[0], 32'h300);
        cyc(); ireq[0] = 0;
        look(); chk("t4_dgnt", 0, 32'(dgnt[0]), 1); chk("t4_addr_d", 0, maddr[0], 32'h400);

        // Two outstanding: request blocked, even during a pop
        cyc(); dreq[0] = 0; ireq[0] = 1; iaddr[0] = 32'h500;
        look(); chk("t5_full_req", 0, 32'(mreq[0]), 0); chk("t5_full_gnt", 0, 32'(igrant[0]), 0);
        cyc(); mrv[0] = 1; merr[0] = 0;
        look(); chk("t5_pop_req", 0, 32'(mreq[0]), 0); chk("t5_pop_irv", 0, 32'(irv[0]), 1);
        cyc(); mrv[0] = 0;
        look(); chk("t5_after_req", 0, 32'(mreq[0]), 1); chk("t5_after_gnt", 0, 32'(igrant[0]), 1);
        cyc(); ireq[0] = 0; mgnt[0] = 0; mrv[0] = 1; merr[0] = 1;
        look(); chk("t5_derr", 0, 32'(derr[0]), 1); chk("t5_ierr", 0, 32'(ierr[0]), 0);
        chk("t5_drv", 0, 32'(drv[0]), 1);
        cyc(); merr[0] = 0;
        look(); chk("t5_last_irv", 0, 32'(irv[0]), 1);

        // Unexpected response, then reset mid-transaction
        cyc(); mrdata[0] = 32'h5555_5555;
        look(); chk("t6_dropped_i", 0, 32'(irv[0]), 0); chk("t6_dropped_d", 0, 32'(drv[0]), 0);
        cyc(); mrv[0] = 0;
        look(); chk("t6_unexp", 0, 32'(unexp[0]), 1);
        cyc();
        look(); chk("t6_unexp_held", 0, 32'(unexp[0]), 1);
        cyc(); ireq[0] = 1; iaddr[0] = 32'h600; mgnt[0] = 1;
        look(); chk("t6_igrant", 0, 32'(igrant[0]), 1);
        cyc(); ireq[0] = 0; mgnt[0] = 0; rst = 1;
        look(); chk("t6_rst_unexp", 0, 32'(unexp[0]), 0); chk("t6_rst_req", 0, 32'(mreq[0]), 0);
        cyc(); rst = 0;
        cyc(); mrv[0] = 1;
        look(); chk("t6_late_irv", 0, 32'(irv[0]), 0);
        cyc(); mrv[0] = 0;
        look(); chk("t6_late_flag", 0, 32'(unexp[0]), 1);

        // Randomised traffic on both instances
        cyc(); rst = 1; clr();
        cyc(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                if (!ireq[m] || seen_ig[m]) begin
                    ireq[m]  = ($urandom_range(0, 2) != 0);
                    iaddr[m] = $urandom & 32'hFFFF_FFFC;
                end else if ($urandom_range(0, 31) == 0) begin
                    ireq[m] = 0;
                end
                if (!dreq[m] || seen_dg[m]) begin
                    dreq[m]   = ($urandom_range(0, 2) != 0);
                    daddr[m]  = $urandom;
                    dwe[m]    = $urandom_range(0, 1) == 1;
                    dbe[m]    = 4'($urandom_range(0, 15));
                    dwdata[m] = $urandom;
                end else if ($urandom_range(0, 31) == 0) begin
                    dreq[m] = 0;
                end
                mgnt[m]   = ($urandom_range(0, 3) != 0);
                mrv[m]    = (cnt_m[m] > 0) && ($urandom_range(0, 1) == 1);
                mrdata[m] = $urandom;
                merr[m]   = ($urandom_range(0, 7) == 0);
            end
        end
        cyc(); clr();
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
